// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer
//  Description : Issues one decoded op to the ALU, waits for done or timeout,
//                updates the flag register by op class, hands result onward.
//                Optional macro ALU_SEQ_FWD_EN lets HOLD accept the next op.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_control,
    input  logic [DATA_W-1:0] in_data_one,
    input  logic [DATA_W-1:0] in_data_two,
    input  logic [3:0]        in_shift,

    output logic [DATA_W-1:0] alu_data_one,
    output logic [DATA_W-1:0] alu_data_two,
    output logic [3:0]        alu_shift,
    output logic [2:0]        alu_control,
    input  logic              alu_done,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [2:0]        alu_flags,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [2:0]        flags_q,
    output logic              err_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [2:0] c_OP_ADD  = 3'b000;
    localparam logic [2:0] c_OP_SUB  = 3'b001;
    localparam logic [2:0] c_OP_NAND = 3'b010;
    localparam logic [2:0] c_OP_XOR  = 3'b011;
    localparam logic [2:0] c_OP_INC  = 3'b100;
    localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 1);

    state_t            r_state;
    logic [7:0]        r_cnt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_err_timeout;
    logic [DATA_W-1:0] r_data_one;
    logic [DATA_W-1:0] r_data_two;
    logic [3:0]        r_shift;
    logic [2:0]        r_control;
    logic [DATA_W-1:0] r_result;
    logic [2:0]        r_flags;

    logic              w_in_fire;
    logic              w_out_fire;
    logic [2:0]        w_flags_next;

`ifdef ALU_SEQ_FWD_EN
    assign in_ready = r_in_ready | ((r_state == ST_HOLD) & out_ready);
`else
    assign in_ready = r_in_ready;
`endif

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    // Logic ops only own Z; shifts leave every flag alone.
    always_comb begin
        w_flags_next = r_flags;
        case (r_control)
            c_OP_ADD, c_OP_SUB, c_OP_INC: w_flags_next = alu_flags;
            c_OP_NAND, c_OP_XOR:          w_flags_next = {alu_flags[2], r_flags[1:0]};
            default:                      w_flags_next = r_flags;
        endcase
    end

    // Operand registers feed the ALU directly so its inputs never move in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_one <= '0;
            r_data_two <= '0;
            r_shift    <= '0;
            r_control  <= '0;
        end else if (w_in_fire) begin
            r_data_one <= in_data_one;
            r_data_two <= in_data_two;
            r_shift    <= in_shift;
            r_control  <= in_control;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_in_ready    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_err_timeout <= 1'b0;
            r_result      <= '0;
            r_flags       <= 3'b000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_in_fire) begin
                        r_in_ready <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (alu_done) begin
                        r_result    <= alu_result;
                        r_flags     <= w_flags_next;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_err_timeout <= 1'b1;
                        r_result      <= '0;
                        r_out_valid   <= 1'b1;
                        r_state       <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (w_out_fire) begin
                        r_out_valid <= 1'b0;
`ifdef ALU_SEQ_FWD_EN
                        if (w_in_fire) begin
                            r_cnt   <= '0;
                            r_state <= ST_WAIT;
                        end else begin
                            r_in_ready <= 1'b1;
                            r_state    <= ST_IDLE;
                        end
`else
                        r_in_ready <= 1'b1;
                        r_state    <= ST_IDLE;
`endif
                    end
                end
                default: begin
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign alu_data_one = r_data_one;
    assign alu_data_two = r_data_two;
    assign alu_shift    = r_shift;
    assign alu_control  = r_control;
    assign out_valid    = r_out_valid;
    assign out_result   = r_result;
    assign flags_q      = r_flags;
    assign err_timeout  = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_op_sequencer
//  Description : Directed self-checking bench for alu_op_sequencer; the bench
//                plays the ALU with hand-computed results and flags.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_control = '0;
    logic [15:0] in_data_one = '0;
    logic [15:0] in_data_two = '0;
    logic [3:0]  in_shift = '0;
    logic [15:0] alu_data_one;
    logic [15:0] alu_data_two;
    logic [3:0]  alu_shift;
    logic [2:0]  alu_control;
    logic        alu_done = 1'b0;
    logic [15:0] alu_result = '0;
    logic [2:0]  alu_flags = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_result;
    logic [2:0]  flags_q;
    logic        err_timeout;

    int n_checks = 0;
    int n_fails  = 0;

    alu_op_sequencer #(.DATA_W(16), .TIMEOUT(15)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_control   (in_control),
        .in_data_one  (in_data_one),
        .in_data_two  (in_data_two),
        .in_shift     (in_shift),
        .alu_data_one (alu_data_one),
        .alu_data_two (alu_data_two),
        .alu_shift    (alu_shift),
        .alu_control  (alu_control),
        .alu_done     (alu_done),
        .alu_result   (alu_result),
        .alu_flags    (alu_flags),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .flags_q      (flags_q),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!in_ready && k < 20) begin
            tick();
            k++;
        end
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic offer(input logic [2:0] ctrl, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] sh);
        in_valid    = 1'b1;
        in_control  = ctrl;
        in_data_one = a;
        in_data_two = b;
        in_shift    = sh;
    endtask

    // One op with ALU done on the first WAIT cycle and out_ready high.
    task automatic run_op(input string tag, input logic [2:0] ctrl, input logic [15:0] a,
                          input logic [15:0] b, input logic [3:0] sh,
                          input logic [15:0] ares, input logic [2:0] aflg,
                          input logic [15:0] eres, input logic [2:0] eflg);
        wait_ready(tag);
        offer(ctrl, a, b, sh);
        tick();
        in_valid = 1'b0;
        check({tag, "_alu_a"}, {16'd0, alu_data_one}, {16'd0, a});
        check({tag, "_alu_ctl"}, {29'd0, alu_control}, {29'd0, ctrl});
        alu_done   = 1'b1;
        alu_result = ares;
        alu_flags  = aflg;
        tick();
        alu_done = 1'b0;
        check({tag, "_oval"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_res"}, {16'd0, out_result}, {16'd0, eres});
        check({tag, "_flags"}, {29'd0, flags_q}, {29'd0, eflg});
        tick();
        check({tag, "_oval_drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_ready_again"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;

        // Reset values
        tick();
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_result", {16'd0, out_result}, 32'd0);
        check("rst_flags", {29'd0, flags_q}, 32'd0);
        check("rst_err", {31'd0, err_timeout}, 32'd0);
        check("rst_alu_a", {16'd0, alu_data_one}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);

        // Arithmetic and flag classes
        run_op("add_ovf", 3'b000, 16'h7FFF, 16'h0001, 4'd0, 16'h8000, 3'b011, 16'h8000, 3'b011);
        run_op("sub_zero", 3'b001, 16'h0005, 16'h0005, 4'd0, 16'h0000, 3'b100, 16'h0000, 3'b100);
        run_op("add_ovf2", 3'b000, 16'h7FFF, 16'h0001, 4'd0, 16'h8000, 3'b011, 16'h8000, 3'b011);
        run_op("xor_z", 3'b011, 16'h00FF, 16'h00FF, 4'd0, 16'h0000, 3'b100, 16'h0000, 3'b111);
        run_op("srl", 3'b110, 16'h8000, 16'h0000, 4'd4, 16'h0800, 3'b000, 16'h0800, 3'b111);
        run_op("inc_wrap", 3'b100, 16'hFFFF, 16'h0000, 4'd0, 16'h0000, 3'b100, 16'h0000, 3'b100);
        run_op("nand", 3'b010, 16'hFFFF, 16'h0000, 4'd0, 16'hFFFF, 3'b001, 16'hFFFF, 3'b000);

        // Backpressure in HOLD with a new op waiting
        wait_ready("bp");
        offer(3'b000, 16'h1234, 16'h0001, 4'd0);
        tick();
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        alu_done   = 1'b1;
        alu_result = 16'h1235;
        alu_flags  = 3'b000;
        tick();
        alu_done = 1'b0;
        offer(3'b001, 16'h0009, 16'h0003, 4'd0);
        for (int i = 0; i < 5; i++) begin
            check("bp_oval", {31'd0, out_valid}, 32'd1);
            check("bp_res", {16'd0, out_result}, 32'h1235);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_alu_a", {16'd0, alu_data_one}, 32'h1234);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_retire", {31'd0, out_valid}, 32'd0);
        check("bp_not_yet", {16'd0, alu_data_one}, 32'h1234);
        tick();
        in_valid = 1'b0;
        check("bp_accept_a", {16'd0, alu_data_one}, 32'h0009);
        check("bp_accept_ctl", {29'd0, alu_control}, 32'd1);
        alu_done   = 1'b1;
        alu_result = 16'h0006;
        alu_flags  = 3'b000;
        tick();
        alu_done = 1'b0;
        check("bp_new_res", {16'd0, out_result}, 32'h0006);
        tick();

        // Timeout
        run_op("pre_to", 3'b000, 16'h7FFF, 16'h0001, 4'd0, 16'h8000, 3'b011, 16'h8000, 3'b011);
        wait_ready("to");
        offer(3'b000, 16'h0001, 16'h0002, 4'd0);
        tick();
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            tick();
            cnt++;
        end
        check("to_cycles", cnt, 32'd15);
        check("to_err", {31'd0, err_timeout}, 32'd1);
        check("to_res", {16'd0, out_result}, 32'd0);
        check("to_flags", {29'd0, flags_q}, 32'b011);
        tick();
        run_op("after_to", 3'b001, 16'h0005, 16'h0005, 4'd0, 16'h0000, 3'b100, 16'h0000, 3'b100);
        check("err_sticky", {31'd0, err_timeout}, 32'd1);

        // Asynchronous reset in WAIT with a pending done
        wait_ready("ar");
        offer(3'b000, 16'h2222, 16'h3333, 4'd0);
        tick();
        in_valid = 1'b0;
        #2;
        alu_done   = 1'b1;
        alu_result = 16'h5555;
        alu_flags  = 3'b011;
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_oval", {31'd0, out_valid}, 32'd0);
        check("ar_flags", {29'd0, flags_q}, 32'd0);
        check("ar_err", {31'd0, err_timeout}, 32'd0);
        check("ar_in_ready", {31'd0, in_ready}, 32'd0);
        check("ar_alu_a", {16'd0, alu_data_one}, 32'd0);
        check("ar_res", {16'd0, out_result}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("ar_rel_ready", {31'd0, in_ready}, 32'd1);
        check("ar_rel_flags", {29'd0, flags_q}, 32'd0);
        check("ar_rel_oval", {31'd0, out_valid}, 32'd0);
        tick();
        check("ar_rel_flags2", {29'd0, flags_q}, 32'd0);
        alu_done = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
